// File: rtl/path_retrace_ctrl.sv
// Move-stack controller for the maze car: records navigator moves and replays them inverted in LIFO order.
// Optional dead-end pruning (U-turn removes the top entry) is enabled by defining PATH_PRUNE_EN.
module path_retrace_ctrl #(
    parameter int DEPTH = 50,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_valid,
    input  logic [1:0]       rec_move,
    output logic             rec_ready,
    input  logic             retrace_start,
    input  logic             abort,
    output logic             out_valid,
    output logic [1:0]       out_move,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [PTR_W-1:0] count,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, OUT, DONE} state_t;

    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

    state_t           state;
    logic [1:0]       mem [DEPTH];
    logic             is_full;
    logic             prune_hit;
    logic             accept;
    logic             push_en;
    logic             drop_en;
    logic [PTR_W-1:0] count_after;
    logic [PTR_W-1:0] top_idx;

    // Swapping the two bits exchanges left/right and leaves forward/U-turn alone.
    function automatic logic [1:0] inv_move(input logic [1:0] m);
        return {m[0], m[1]};
    endfunction

    always_comb begin
        is_full = (count == FULL);
`ifdef PATH_PRUNE_EN
        prune_hit = (rec_move == 2'b11);
`else
        prune_hit = 1'b0;
`endif
        rec_ready   = (state == IDLE) && (!is_full || prune_hit);
        accept      = rec_valid && rec_ready;
        push_en     = accept && !prune_hit;
        drop_en     = (state == IDLE) && rec_valid && is_full && !prune_hit;
        top_idx     = count - 1'b1;
        count_after = count;
        if (accept && prune_hit) begin
            if (count != '0) begin
                count_after = count - 1'b1;
            end
        end else if (push_en) begin
            count_after = count + 1'b1;
        end
    end

    // Storage is never reset; count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[count] <= rec_move;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            out_move  <= 2'b00;
            done      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    count <= count_after;
                    if (drop_en) begin
                        overflow <= 1'b1;
                    end
                    // A move accepted alongside retrace_start is counted before choosing LOAD vs DONE.
                    if (retrace_start) begin
                        if (count_after != '0) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        out_move  <= inv_move(mem[top_idx]);
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= count - 1'b1;
                        if (count == PTR_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_retrace_ctrl.sv
// Self-checking bench for path_retrace_ctrl: directed and randomized record/retrace against a queue-based stack model.
module tb_path_retrace_ctrl;

    localparam int DEPTH = 50;
    localparam int PTR_W = 6;
`ifdef PATH_PRUNE_EN
    localparam bit PRUNE = 1'b1;
`else
    localparam bit PRUNE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             rec_valid;
    logic [1:0]       rec_move;
    logic             rec_ready;
    logic             retrace_start;
    logic             abort;
    logic             out_valid;
    logic [1:0]       out_move;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [PTR_W-1:0] count;
    logic             overflow;

    path_retrace_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .rec_valid(rec_valid), .rec_move(rec_move), .rec_ready(rec_ready),
        .retrace_start(retrace_start), .abort(abort),
        .out_valid(out_valid), .out_move(out_move), .out_ready(out_ready),
        .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] stk[$];
    bit         ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] inv_ref(input logic [1:0] m);
        case (m)
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return m;
        endcase
    endfunction

    function automatic bit exp_ready(input logic [1:0] m);
        return (stk.size() != DEPTH) || (PRUNE && m == 2'd3);
    endfunction

    function automatic void model_push(input logic [1:0] m);
        if (PRUNE && m == 2'd3) begin
            if (stk.size() > 0) void'(stk.pop_back());
        end else if (stk.size() == DEPTH) begin
            ovf_m = 1'b1;
        end else begin
            stk.push_back(m);
        end
    endfunction

    task automatic push(input logic [1:0] m);
        @(negedge clk);
        rec_valid = 1'b1;
        rec_move  = m;
        #1 chk("rec_ready", rec_ready, exp_ready(m));
        @(posedge clk);
        model_push(m);
        #1 rec_valid = 1'b0;
        chk("push_count", count, stk.size());
        chk("overflow", overflow, ovf_m);
    endtask

    // abort_at / rst_at: pop index at which to abort or reset during OUT (-1 = never).
    task automatic retrace(input int stall_first, input int abort_at, input int rst_at,
                           input bit with_push, input logic [1:0] pm, input int ready_pct);
        int  pops = 0;
        int  stalls = 0;
        bit  rdy;
        bit  accepted;
        @(negedge clk);
        retrace_start = 1'b1;
        if (with_push) begin
            rec_valid = 1'b1;
            rec_move  = pm;
            #1 chk("start_rec_ready", rec_ready, exp_ready(pm));
        end
        @(posedge clk);
        if (with_push) model_push(pm);
        #1 retrace_start = 1'b0;
        rec_valid = 1'b0;
        if (stk.size() == 0) begin
            @(negedge clk);
            chk("empty_done", done, 1);
            chk("empty_valid", out_valid, 0);
            @(negedge clk);
            chk("empty_done_drop", done, 0);
            chk("empty_valid2", out_valid, 0);
            return;
        end
        while (stk.size() > 0) begin
            @(negedge clk);
            chk("load_valid", out_valid, 0);
            chk("load_busy", busy, 1);
            chk("load_rec_ready", rec_ready, 0);
            accepted = 1'b0;
            for (int c = 0; c < 64 && !accepted; c++) begin
                @(negedge clk);
                chk("out_valid", out_valid, 1);
                chk("out_move", out_move, inv_ref(stk[$]));
                chk("out_count", count, stk.size());
                chk("out_done", done, 0);
                if (abort_at == pops || rst_at == pops) begin
                    if (abort_at == pops) abort = 1'b1;
                    else rst = 1'b1;
                    out_ready = 1'b1;
                    @(posedge clk);
                    #1 abort = 1'b0;
                    out_ready = 1'b0;
                    if (rst) begin
                        rst = 1'b0;
                        stk.delete();
                        ovf_m = 1'b0;
                        chk("rst_overflow", overflow, 0);
                    end
                    chk("stop_valid", out_valid, 0);
                    chk("stop_busy", busy, 0);
                    chk("stop_done", done, 0);
                    chk("stop_count", count, stk.size());
                    return;
                end
                rdy = (stalls < stall_first) ? 1'b0 : ($urandom_range(99) < ready_pct);
                stalls++;
                out_ready = rdy;
                @(posedge clk);
                #1 out_ready = 1'b0;
                if (rdy) begin
                    void'(stk.pop_back());
                    pops++;
                    accepted = 1'b1;
                end
            end
            if (!accepted) begin
                chk("out_timeout", 0, 1);
                return;
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("end_count", count, 0);
        chk("end_rec_ready", rec_ready, exp_ready(rec_move));
    endtask

    initial begin
        rst = 1'b1; rec_valid = 1'b0; rec_move = 2'b00;
        retrace_start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_move", out_move, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rec_ready", rec_ready, 1);

        // basic record then full retrace
        push(2'd1); push(2'd0); push(2'd2);
        retrace(0, -1, -1, 0, 2'd0, 100);

        // fill to DEPTH, then an extra offer is dropped
        for (int i = 0; i < DEPTH; i++) push(2'($urandom_range(2)));
        push(2'($urandom_range(2)));
        chk("full_overflow", overflow, 1);
        chk("full_count", count, DEPTH);
        retrace(0, -1, -1, 0, 2'd0, 60);

        // backpressure
        push(2'd1); push(2'd2); push(2'd3);
        retrace(5, -1, -1, 0, 2'd0, 100);

        // abort after one pop
        for (int i = 0; i < 4; i++) push(2'($urandom_range(3)));
        retrace(0, 1, -1, 0, 2'd0, 100);
        retrace(0, -1, -1, 0, 2'd0, 70);

        // empty retrace
        retrace(0, -1, -1, 0, 2'd0, 100);

        // push in the same cycle as retrace_start
        push(2'd0); push(2'd1);
        retrace(0, -1, -1, 1, 2'd2, 100);

`ifdef PATH_PRUNE_EN
        push(2'd0); push(2'd1); push(2'd3);
        chk("prune_count", count, 1);
        retrace(0, -1, -1, 0, 2'd0, 100);
`endif

        for (int r = 0; r < 20; r++) begin
            int n;
            int ab;
            n  = $urandom_range(8);
            for (int i = 0; i < n; i++) push(2'($urandom_range(3)));
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
            retrace($urandom_range(2), ab, -1, bit'($urandom_range(1)),
                    2'($urandom_range(3)), $urandom_range(30, 100));
        end

        // reset in the middle of a retrace clears the stack
        for (int i = 0; i < 5; i++) push(2'($urandom_range(2)));
        retrace(0, -1, 2, 0, 2'd0, 100);
        push(2'd1);
        retrace(0, -1, -1, 0, 2'd0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/path_retrace_ctrl.md
# path_retrace_ctrl

Controller that owns the 2-bit move stack for the maze car and sequences its use. In record mode it accepts moves from the navigator, one per handshake, and pushes them. In retrace mode it pops moves back out in LIFO order, inverts each one, and streams it to the motor sequencer through a valid/ready handshake until the stack is empty. The block sits between the navigator FSM and the motor controller, and replaces ad-hoc pulse-driven push/pop with handshaked, arbitrated access.

## Interface
- DEPTH, 50, number of 2-bit move entries
- PTR_W, 6, width of the entry counter; must satisfy 2^PTR_W > DEPTH
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rec_valid  in  1  navigator offers a move
- rec_move  in  2  move code: 00 forward, 01 left, 10 right, 11 U-turn
- rec_ready  out  1  block accepts a move this cycle
- retrace_start  in  1  level request to begin retrace
- abort  in  1  cancel an in-progress retrace
- out_valid  out  1  out_move holds a retrace move
- out_move  out  2  inverted popped move
- out_ready  in  1  motor sequencer accepts out_move
- busy  out  1  high in LOAD or OUT
- done  out  1  one-cycle pulse when retrace completes
- count  out  PTR_W  number of stored entries
- overflow  out  1  sticky flag, set when a push is attempted while full

## Operation
- The FSM has four states: IDLE, LOAD, OUT and DONE.
- IDLE (record mode):
  - rec_ready = !(count == DEPTH).
  - When rec_valid && rec_ready: mem[count] <= rec_move and count increments.
  - When rec_valid && count == DEPTH: the move is dropped and overflow is set to 1.
- IDLE to retrace:
  - retrace_start = 1 while in IDLE: the next state is LOAD if the post-push count > 0, otherwise DONE.
  - If rec_valid is accepted in the same cycle as retrace_start, the push takes effect first and that move is the first one replayed.
- LOAD: out_move <= inv(mem[count-1]). Next state is OUT.
- OUT:
  - out_valid = 1 and out_move is held stable until it is accepted.
  - On out_ready, count decrements. The next state is DONE if the new count is 0, otherwise LOAD.
- DONE: done = 1 for exactly one cycle, then the FSM returns to IDLE.
- Inversion: 01↔10; 00 and 11 are unchanged.
- abort:
  - Asserted in LOAD or OUT: the next state is IDLE, out_valid drops, and no decrement occurs, even if out_ready is also high that cycle.
  - Entries not yet popped are retained.
  - abort is ignored in IDLE and DONE.
- rec_ready = 0 in every state other than IDLE; rec_valid is ignored there.
- Memory contents are not reset. count alone defines validity.

## Timing
- Reset values: state IDLE, count 0, out_valid 0, out_move 00, done 0, overflow 0, busy 0, rec_ready 1.
- Push latency: count updates on the edge following acceptance.
- Retrace latency:
  - retrace_start is sampled in IDLE at cycle N.
  - LOAD is at N+1 and out_valid is first high at N+2.
- Throughput: each pop costs LOAD plus at least one OUT cycle, i.e. a maximum of one move per 2 cycles.
- Empty retrace: retrace_start at N with count 0 gives done = 1 at N+1, with no out_valid.
- Full: count == DEPTH drives rec_ready low combinationally in the same cycle.
- rst mid-retrace: on the next edge the FSM is in IDLE, count is 0 and out_valid is 0. The stack is cleared.
- overflow clears only on rst.

## Configuration
- PATH_PRUNE_EN (defined): dead-end pruning.
  - An accepted rec_move = 11 with count > 0 decrements count (removes the top entry) instead of pushing.
  - An accepted rec_move = 11 with count == 0 is discarded.
  - rec_ready when count == DEPTH is 1 for rec_move = 11; overflow is never set by an 11.
- PATH_PRUNE_EN (undefined): 11 is pushed like any other code.

## Test plan
- Reset, then push 01, 00, 10, then retrace with out_ready held 1 -> out_move 01, 00, 10 on successive OUT cycles; done pulses once; count is 0.
- Push 50 moves, then offer a 51st -> rec_ready = 0 at count 50; overflow = 1; count stays 50; the first retrace output is the inverse of move 50.
- Push 3 moves; start retrace; hold out_ready = 0 for 5 cycles -> out_valid high with out_move stable, count stays 3; releasing out_ready pops exactly one entry.
- Push 4 moves; retrace; assert abort in the OUT cycle after one pop -> IDLE next cycle, out_valid 0, count 3, no done.
- retrace_start with count 0 -> done at N+1, out_valid never asserted.
- PATH_PRUNE_EN defined: push 00, 01, then 11 -> count 1; retrace yields the single move 00.
